// File: rtl/bvudiv_uge_checker_if.sv
// Handshake bundle for the (x udiv s) >= t checker: candidate input channel
// and result channel, each with its own valid/ready pair.
interface bvudiv_uge_checker_if #(
  parameter int W  = 4,
  parameter int CW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  s;
  logic [W-1:0]  t;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  quot;
  logic [W-1:0]  rem;
  logic          sat;
  logic [CW-1:0] fail_cnt;

  modport master (
    output in_valid, x, s, t, out_ready,
    input  in_ready, out_valid, quot, rem, sat, fail_cnt
  );

  modport slave (
    input  in_valid, x, s, t, out_ready,
    output in_ready, out_valid, quot, rem, sat, fail_cnt
  );
endinterface

// File: rtl/bvudiv_uge_checker.sv
// Serial restoring divider that checks a Skolem candidate against (x udiv s) >= t,
// one quotient bit per cycle, with a saturating count of failing candidates.
module bvudiv_uge_checker #(
  parameter int W  = 4,
  parameter int CW = 16
) (
  input logic                 clk,
  input logic                 rst,
  bvudiv_uge_checker_if.slave bus
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    s_q, s_d;
  logic [W-1:0]    t_q, t_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quot_q, quot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   fail_cnt_q, fail_cnt_d;

  logic [W:0]      p_s;
  logic            ge_s;
  logic            sat_s;
  logic            fail_max_s;

  // Next-state, datapath iteration and failure accounting.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    s_d        = s_q;
    t_d        = t_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    fail_cnt_d = fail_cnt_q;

    // x_q is consumed MSB-first by shifting it left each iteration.
    p_s        = {rem_q, x_q[W-1]};
    ge_s       = (p_s >= {1'b0, s_q});
    sat_s      = out_valid_q & (quot_q >= t_q);
    fail_max_s = &fail_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          x_d     = bus.x;
          s_d     = bus.s;
          t_d     = bus.t;
          rem_d   = {W{1'b0}};
          quot_d  = {W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        x_d    = {x_q[W-2:0], 1'b0};
        quot_d = {quot_q[W-2:0], ge_s};
        if (ge_s) begin
          rem_d = W'(p_s - {1'b0, s_q});
        end else begin
          rem_d = p_s[W-1:0];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          if (!sat_s && !fail_max_s) begin
            fail_cnt_d = fail_cnt_q + CW'(1);
          end else begin
            fail_cnt_d = fail_cnt_q;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= {W{1'b0}};
      s_q         <= {W{1'b0}};
      t_q         <= {W{1'b0}};
      rem_q       <= {W{1'b0}};
      quot_q      <= {W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fail_cnt_q  <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      s_q         <= s_d;
      t_q         <= t_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quot      = quot_q;
  assign bus.rem       = rem_q;
  assign bus.sat       = sat_s;
  assign bus.fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_bvudiv_uge_checker.sv
// Randomized and directed bench for bvudiv_uge_checker against an arithmetic
// reference model of SMT-LIB bvudiv/bvurem and unsigned >=.
module tb_bvudiv_uge_checker;
  localparam int W  = 4;
  localparam int CW = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   exp_fail;

  bvudiv_uge_checker_if #(.W(W), .CW(CW)) bus ();

  bvudiv_uge_checker #(.W(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {quot, rem, sat}
  function automatic logic [2*W:0] model(input int xi, input int si, input int ti);
    int q;
    int r;
    if (si == 0) begin
      q = (1 << W) - 1;
      r = xi;
    end else begin
      q = xi / si;
      r = xi % si;
    end
    return {q[W-1:0], r[W-1:0], (q >= ti)};
  endfunction

  task automatic start_op(input int xi, input int si, input int ti);
    int n;
    n = 0;
    @(negedge clk);
    bus.x = xi[W-1:0];
    bus.s = si[W-1:0];
    bus.t = ti[W-1:0];
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.out_valid !== 1'b1 && cyc < 50);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.quot, bus.rem, bus.sat, bus.fail_cnt} !== {1'b1, 1'b0, {(2*W+1+CW){1'b0}}}) begin
      bad++;
      $display("FAIL reset_async got rdy=%b vld=%b q=%0d r=%0d sat=%b fc=%0d", bus.in_ready, bus.out_valid, bus.quot, bus.rem, bus.sat, bus.fail_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_fail = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.in_ready, bus.out_valid, bus.sat, bus.fail_cnt} !== {1'b1, 1'b0, 1'b0, {CW{1'b0}}}) begin
      bad++;
      $display("FAIL idle_out_ready got rdy=%b vld=%b sat=%b fc=%0d exp rdy=1 vld=0 sat=0 fc=0", bus.in_ready, bus.out_valid, bus.sat, bus.fail_cnt);
    end
  endtask

  task automatic test_nominal();
    int cyc;
    start_op(13, 3, 4);
    wait_valid(cyc);
    total++;
    if (cyc !== W + 1) begin
      bad++;
      $display("FAIL nominal_latency got=%0d exp=%0d", cyc, W + 1);
    end
    total++;
    if ({bus.quot, bus.rem, bus.sat} !== {4'd4, 4'd1, 1'b1}) begin
      bad++;
      $display("FAIL nominal_result got q=%0d r=%0d sat=%b exp q=4 r=1 sat=1", bus.quot, bus.rem, bus.sat);
    end
    consume();
    @(negedge clk);
    total++;
    if ({bus.in_ready, bus.out_valid, bus.fail_cnt} !== {1'b1, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL nominal_after got rdy=%b vld=%b fc=%0d exp rdy=1 vld=0 fc=0", bus.in_ready, bus.out_valid, bus.fail_cnt);
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    start_op(5, 0, 15);
    wait_valid(cyc);
    total++;
    if ({bus.quot, bus.rem, bus.sat} !== {4'd15, 4'd5, 1'b1}) begin
      bad++;
      $display("FAIL divzero_5 got q=%0d r=%0d sat=%b exp q=15 r=5 sat=1", bus.quot, bus.rem, bus.sat);
    end
    consume();
    start_op(0, 0, 15);
    wait_valid(cyc);
    total++;
    if ({bus.quot, bus.rem, bus.sat} !== {4'd15, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL divzero_0 got q=%0d r=%0d sat=%b exp q=15 r=0 sat=1", bus.quot, bus.rem, bus.sat);
    end
    consume();
  endtask

  task automatic test_fail();
    int cyc;
    start_op(2, 7, 1);
    wait_valid(cyc);
    total++;
    if ({bus.quot, bus.rem, bus.sat} !== {4'd0, 4'd2, 1'b0}) begin
      bad++;
      $display("FAIL failing_result got q=%0d r=%0d sat=%b exp q=0 r=2 sat=0", bus.quot, bus.rem, bus.sat);
    end
    @(negedge clk);
    total++;
    if (bus.fail_cnt !== CW'(exp_fail)) begin
      bad++;
      $display("FAIL fail_cnt_early got=%0d exp=%0d", bus.fail_cnt, exp_fail);
    end
    consume();
    exp_fail++;
    total++;
    if (bus.fail_cnt !== CW'(exp_fail)) begin
      bad++;
      $display("FAIL fail_cnt_consume got=%0d exp=%0d", bus.fail_cnt, exp_fail);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    start_op(13, 3, 4);
    wait_valid(cyc);
    for (int i = 0; i < 3; i++) begin
      bus.x = W'($urandom);
      bus.s = W'($urandom);
      bus.t = W'($urandom);
      bus.in_valid = ~bus.in_valid;
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.in_ready, bus.quot, bus.rem, bus.sat, bus.fail_cnt} !== {1'b1, 1'b0, 4'd4, 4'd1, 1'b1, CW'(exp_fail)}) begin
        bad++;
        $display("FAIL backpressure_hold got vld=%b rdy=%b q=%0d r=%0d sat=%b fc=%0d exp vld=1 rdy=0 q=4 r=1 sat=1 fc=%0d", bus.out_valid, bus.in_ready, bus.quot, bus.rem, bus.sat, bus.fail_cnt, exp_fail);
      end
    end
    bus.in_valid = 1'b0;
    consume();
    @(negedge clk);
    total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL backpressure_release got rdy=%b vld=%b exp rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    start_op(13, 3, 4);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_fail = 0;
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.fail_cnt} !== {1'b1, 1'b0, {CW{1'b0}}}) begin
      bad++;
      $display("FAIL reset_mid got rdy=%b vld=%b fc=%0d exp rdy=1 vld=0 fc=0", bus.in_ready, bus.out_valid, bus.fail_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    start_op(9, 2, 5);
    wait_valid(cyc);
    total++;
    if (cyc !== W + 1 || {bus.quot, bus.rem, bus.sat} !== {4'd4, 4'd1, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_next got lat=%0d q=%0d r=%0d sat=%b exp lat=%0d q=4 r=1 sat=0", cyc, bus.quot, bus.rem, bus.sat, W + 1);
    end
    consume();
    exp_fail++;
  endtask

  task automatic test_random();
    int cyc;
    int xi, si, ti;
    logic [2*W:0] e;
    for (int k = 0; k < 24; k++) begin
      xi = int'($urandom_range(0, 15));
      si = int'($urandom_range(0, 15));
      ti = int'($urandom_range(0, 15));
      e = model(xi, si, ti);
      start_op(xi, si, ti);
      wait_valid(cyc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      total++;
      if (cyc !== W + 1 || {bus.quot, bus.rem, bus.sat} !== e) begin
        bad++;
        $display("FAIL random x=%0d s=%0d t=%0d got lat=%0d qrs=%h exp lat=%0d qrs=%h", xi, si, ti, cyc, {bus.quot, bus.rem, bus.sat}, W + 1, e);
      end
      consume();
      if (e[0] == 1'b0) exp_fail++;
    end
    @(negedge clk);
    total++;
    if (bus.fail_cnt !== CW'(exp_fail)) begin
      bad++;
      $display("FAIL random_fail_cnt got=%0d exp=%0d", bus.fail_cnt, exp_fail);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W:0] q[$];
    logic [2*W:0] e;
    logic [11:0]  v;
    int cycles;
    int idx;
    int done;
    cycles = 0;
    idx = 0;
    done = 0;
    bus.out_ready = 1'b1;
    while (done < 4096 && cycles < 30000) begin
      @(negedge clk);
      cycles++;
      if (bus.out_valid === 1'b1) begin
        e = (q.size() > 0) ? q.pop_front() : {(2*W+1){1'bx}};
        total++;
        if ({bus.quot, bus.rem, bus.sat} !== e) begin
          bad++;
          $display("FAIL sweep idx=%0d got qrs=%h exp qrs=%h", done, {bus.quot, bus.rem, bus.sat}, e);
        end
        if (e[0] == 1'b0) exp_fail++;
        done++;
      end
      if (bus.in_ready === 1'b1) begin
        if (idx < 4096) begin
          v = idx[11:0];
          bus.x = v[11:8];
          bus.s = v[7:4];
          bus.t = v[3:0];
          bus.in_valid = 1'b1;
          q.push_back(model(int'(v[11:8]), int'(v[7:4]), int'(v[3:0])));
          idx++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (cycles !== 4096 * (W + 2) || done !== 4096) begin
      bad++;
      $display("FAIL sweep_cycles got=%0d results=%0d exp=%0d results=4096", cycles, done, 4096 * (W + 2));
    end
    total++;
    if (bus.fail_cnt !== CW'(exp_fail)) begin
      bad++;
      $display("FAIL sweep_fail_cnt got=%0d exp=%0d", bus.fail_cnt, exp_fail);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_fail = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x = '0;
    bus.s = '0;
    bus.t = '0;
    test_reset();
    test_nominal();
    test_div_zero();
    test_fail();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
